restoring_divider_8bit: RTL



---
 rtl/div_pkg.sv | 16 +
 rtl/addsub_nbit.sv | 29 ++
 rtl/restoring_divider_8bit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
//   state_t   : divider control states
//   DIV_WIDTH : default operand width
//   CNT_W     : iteration counter width for DIV_WIDTH
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_nbit.sv
// WIDTH-bit ripple-carry adder/subtractor.
//   a, b  : operands
//   sub   : 1 -> a + ~b + 1 (a - b), 0 -> a + b
//   sum   : WIDTH-bit result
//   c_out : carry out of the top bit (1 = no borrow when subtracting)
module addsub_nbit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;

    assign b_eff    = b ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/restoring_divider_8bit.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, accepted only while busy=0
//   dividend, divisor   : operands, captured on the accepting edge
//   busy                : division iterations in progress
//   done                : one-cycle completion pulse
//   quotient, remainder : results, held until the next completion
//   div_by_zero         : divisor was zero, held until the next completion
//
// state | meaning
// IDLE  | waiting for start (or finishing a divide-by-zero request)
// RUN   | one shift/trial-subtract iteration per cycle
// DONE  | completion cycle, start here is accepted back-to-back
module restoring_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);

    state_t state, state_next;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;
    logic             dz_pend;

    logic             accept;
    logic             load;
    logic             last;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             carry_unused;
    logic             a_msb_unused;

    // A's top bit is always zero between iterations (partial remainder < M),
    // so only the low bits feed the shift.
    assign a_msb_unused = a_reg[WIDTH];

    // A divide-by-zero request spends one cycle pending before DONE, so no new
    // request may be accepted during that cycle.
    assign accept = start && (state != RUN) && !dz_pend;
    assign load   = accept && (divisor != '0);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    addsub_nbit #(.WIDTH(WIDTH + 1)) u_addsub (
        .a     (a_shift),
        .b     ({1'b0, m_reg}),
        .sub   (1'b1),
        .sum   (trial),
        .c_out (carry_unused)
    );

    assign trial_neg = trial[WIDTH];
    assign a_next    = trial_neg ? a_shift : trial;
    assign q_next    = {q_reg[WIDTH-2:0], ~trial_neg};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    state_next = RUN;
                end else if (dz_pend) begin
                    state_next = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                state_next = last ? DONE : RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            dz_pend <= accept && (divisor == '0);
            done    <= last || dz_pend;

            if (load) begin
                a_reg <= '0;
                q_reg <= dividend;
                m_reg <= divisor;
                cnt   <= '0;
            end else if (accept) begin
                // Divide by zero: park the dividend until the result is written.
                q_reg <= dividend;
            end else if (state == RUN) begin
                a_reg <= a_next;
                q_reg <= q_next;
                cnt   <= cnt + 1'b1;
            end

            if (last) begin
                quotient    <= q_next;
                remainder   <= a_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end else if (dz_pend) begin
                quotient    <= '1;
                remainder   <= q_reg;
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule
